// File: rtl/dft8.sv
// dft8: unscaled 8-point radix-2 DIT forward DFT, combinational butterflies into one output register stage.
module dft8 #(
    parameter int N = 32,
    parameter int P = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [N-1:0] ar, ai, br, bi, cr, ci, dr, di,
    input  logic signed [N-1:0] er, ei, fr, fi, gr, gi, hr, hi,
    output logic signed [N-1:0] AAAr, AAAi, BBBr, BBBi, CCCr, CCCi, DDDr, DDDi,
    output logic signed [N-1:0] EEEr, EEEi, FFFr, FFFi, GGGr, GGGi, HHHr, HHHi,
    output logic                out_valid
);
    localparam int C = int'(0.70710678 * (2.0 ** P));
    localparam logic signed [2*N-1:0] CW = (2*N)'(C);

    // Product kept at 2N bits so the floor shift sees the full value before truncation.
    function automatic logic signed [N-1:0] twm(input logic signed [N-1:0] s);
        logic signed [2*N-1:0] se;
        se = (2*N)'(s);
        return N'((se * CW) >>> P);
    endfunction

    logic signed [N-1:0] x_re [8], x_im [8];
    logic signed [N-1:0] s_re [4], s_im [4], d_re [4], d_im [4];
    logic signed [N-1:0] h_re [2][4], h_im [2][4];
    logic signed [N-1:0] tw_re [4], tw_im [4];
    logic signed [N-1:0] y_re_d [8], y_im_d [8], y_re_q [8], y_im_q [8];
    logic                out_valid_d, out_valid_q;

    assign x_re = '{ar, br, cr, dr, er, fr, gr, hr};
    assign x_im = '{ai, bi, ci, di, ei, fi, gi, hi};

    always_comb begin
        for (int m = 0; m < 4; m++) begin
            s_re[m] = x_re[m] + x_re[m+4];
            s_im[m] = x_im[m] + x_im[m+4];
            d_re[m] = x_re[m] - x_re[m+4];
            d_im[m] = x_im[m] - x_im[m+4];
        end
        // q=0 builds the even half (x0,x2,x4,x6), q=1 the odd half; -j*(a+jb) = b-ja.
        for (int q = 0; q < 2; q++) begin
            h_re[q][0] = s_re[q] + s_re[q+2];
            h_im[q][0] = s_im[q] + s_im[q+2];
            h_re[q][2] = s_re[q] - s_re[q+2];
            h_im[q][2] = s_im[q] - s_im[q+2];
            h_re[q][1] = d_re[q] + d_im[q+2];
            h_im[q][1] = d_im[q] - d_re[q+2];
            h_re[q][3] = d_re[q] - d_im[q+2];
            h_im[q][3] = d_im[q] + d_re[q+2];
        end
        tw_re[0] = h_re[1][0];
        tw_im[0] = h_im[1][0];
        tw_re[1] = twm(h_re[1][1] + h_im[1][1]);
        tw_im[1] = twm(h_im[1][1] - h_re[1][1]);
        tw_re[2] = h_im[1][2];
        tw_im[2] = -h_re[1][2];
        tw_re[3] = twm(h_im[1][3] - h_re[1][3]);
        tw_im[3] = twm(-(h_re[1][3] + h_im[1][3]));
        for (int k = 0; k < 4; k++) begin
            y_re_d[k]   = in_valid ? h_re[0][k] + tw_re[k] : y_re_q[k];
            y_im_d[k]   = in_valid ? h_im[0][k] + tw_im[k] : y_im_q[k];
            y_re_d[k+4] = in_valid ? h_re[0][k] - tw_re[k] : y_re_q[k+4];
            y_im_d[k+4] = in_valid ? h_im[0][k] - tw_im[k] : y_im_q[k+4];
        end
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                y_re_q[k] <= '0;
                y_im_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
        end else begin
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign {AAAr, BBBr, CCCr, DDDr} = {y_re_q[0], y_re_q[1], y_re_q[2], y_re_q[3]};
    assign {EEEr, FFFr, GGGr, HHHr} = {y_re_q[4], y_re_q[5], y_re_q[6], y_re_q[7]};
    assign {AAAi, BBBi, CCCi, DDDi} = {y_im_q[0], y_im_q[1], y_im_q[2], y_im_q[3]};
    assign {EEEi, FFFi, GGGi, HHHi} = {y_im_q[4], y_im_q[5], y_im_q[6], y_im_q[7]};
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_dft8.sv
// tb_dft8: scoreboard bench for dft8 with directed vectors and hand-computed bins.
module tb_dft8;
    typedef struct packed {
        logic [7:0]       id;
        logic [7:0][31:0] re;
        logic [7:0][31:0] im;
    } vec_t;

    logic             clk, rst_n, in_valid;
    logic [7:0][31:0] xin_re, xin_im, got_re, got_im;
    logic             out_valid;
    logic [7:0][31:0] xr, xi, er, ei;
    vec_t             sb[$];
    int               tests = 0;
    int               fails = 0;

    int mix_er[8] = '{72, -16, 0, 0, -8, -16, -16, 0};
    int mix_ei[8] = '{64, 0, 0, 6, 8, 0, -16, -38};
    int sh_er[8]  = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    int sh_ei[8]  = '{0, -724, -1024, -724, 0, 724, 1024, 724};

    dft8 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .ar(xin_re[0]), .ai(xin_im[0]), .br(xin_re[1]), .bi(xin_im[1]),
        .cr(xin_re[2]), .ci(xin_im[2]), .dr(xin_re[3]), .di(xin_im[3]),
        .er(xin_re[4]), .ei(xin_im[4]), .fr(xin_re[5]), .fi(xin_im[5]),
        .gr(xin_re[6]), .gi(xin_im[6]), .hr(xin_re[7]), .hi(xin_im[7]),
        .AAAr(got_re[0]), .AAAi(got_im[0]), .BBBr(got_re[1]), .BBBi(got_im[1]),
        .CCCr(got_re[2]), .CCCi(got_im[2]), .DDDr(got_re[3]), .DDDi(got_im[3]),
        .EEEr(got_re[4]), .EEEi(got_im[4]), .FFFr(got_re[5]), .FFFi(got_im[5]),
        .GGGr(got_re[6]), .GGGi(got_im[6]), .HHHr(got_re[7]), .HHHi(got_im[7]),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0][31:0] pk(input int a[8]);
        logic [7:0][31:0] r;
        for (int k = 0; k < 8; k++) r[k] = 32'(a[k]);
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] g, input logic [31:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, k, $signed(g), $signed(e));
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0][31:0] re, input logic [7:0][31:0] im, input logic v);
        for (int k = 0; k < 8; k++) begin
            chk({nm, "_re"}, k, got_re[k], re[k]);
            chk({nm, "_im"}, k, got_im[k], im[k]);
        end
        chk({nm, "_valid"}, 0, 32'(out_valid), 32'(v));
    endtask

    task automatic send(input logic [7:0][31:0] r, input logic [7:0][31:0] i,
                        input logic [7:0][31:0] e_re, input logic [7:0][31:0] e_im, input logic [7:0] id);
        @(negedge clk);
        xin_re   = r;
        xin_im   = i;
        in_valid = 1'b1;
        sb.push_back('{id: id, re: e_re, im: e_im});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: every out_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid got 1 expected 0");
            end else begin
                vec_t v;
                v = sb.pop_front();
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("vec%0d_X_re", v.id), k, got_re[k], v.re[k]);
                    chk($sformatf("vec%0d_X_im", v.id), k, got_im[k], v.im[k]);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            xin_re[k] = 32'(k * 37 + 11);
            xin_im[k] = 32'(-k * 5 - 3);
        end
        #2;
        chk_all("reset", '0, '0, 1'b0);
        #20;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            xr[k] = 32'(2 * k + 2);
            xi[k] = 32'((k == 7) ? 1 : 2 * k + 3);
        end
        send(xr, xi, pk(mix_er), pk(mix_ei), 8'd1);
        xr = '0; xi = '0; xr[0] = 32'd1024;
        er = {8{32'd1024}}; ei = '0;
        send(xr, xi, er, ei, 8'd2);
        xr = '0; xr[1] = 32'd1024;
        send(xr, xi, pk(sh_er), pk(sh_ei), 8'd3);
        xr = {8{32'd5}}; er = '0; er[0] = 32'd40;
        send(xr, xi, er, ei, 8'd4);
        idle();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midreset", '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        xr = {8{32'h7fff_ffff}}; xi = '0;
        er = '0; er[0] = 32'hffff_fff8;
        send(xr, xi, er, '0, 8'd5);
        idle();
        for (int k = 0; k < 8; k++) begin
            xin_re[k] = 32'(k + 100);
            xin_im[k] = 32'(k - 100);
        end
        repeat (3) @(negedge clk);
        #1;
        chk_all("hold", er, '0, 1'b0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
